// File: rtl/rf_pkg.sv
// Shared sizes and types for the register-file access controller.
package rf_pkg;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 2;
  localparam int NREG   = 1 << IDX_W;

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NREG-1:0]   reg_mask_t;

  // One-hot mask for a register index, or all-zero when not enabled.
  function automatic reg_mask_t idx_mask(input reg_idx_t idx, input logic en);
    return en ? (reg_mask_t'(1) << idx) : '0;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with set-over-clear priority,
// hazard queries for the issuing instruction, and the sticky error flag
// raised by a writeback to a register that had no write outstanding.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en_i,
  input  reg_idx_t  set_idx_i,
  input  logic      clr_en_i,
  input  reg_idx_t  clr_idx_i,
  input  reg_idx_t  src1_i,
  input  logic      use1_i,
  input  reg_idx_t  src2_i,
  input  logic      use2_i,
  input  reg_idx_t  dst_i,
  input  logic      wb_i,
  output reg_mask_t pend_o,
  output reg_mask_t pend_eff_o,
  output logic [2:0] hazard_o,
  output logic      wb_err_o
);
  reg_mask_t pend_q, pend_d;
  reg_mask_t set_mask, clr_mask;
  logic      err_q, err_d;

  // A writeback in this cycle already frees its register for a new reader,
  // and an issue that sets the same index as the clear keeps it pending.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign set_mask[gi] = set_en_i && (set_idx_i == reg_idx_t'(gi));
      assign clr_mask[gi] = clr_en_i && (clr_idx_i == reg_idx_t'(gi));
      assign pend_d[gi]   = set_mask[gi] | (pend_q[gi] & ~clr_mask[gi]);
    end
  endgenerate

  assign pend_eff_o = pend_q & ~clr_mask;

  assign hazard_o[0] = use1_i && pend_eff_o[src1_i];
  assign hazard_o[1] = use2_i && pend_eff_o[src2_i];
  assign hazard_o[2] = wb_i   && pend_eff_o[dst_i];

  assign err_d    = err_q | (clr_en_i && !pend_q[clr_idx_i]);
  assign pend_o   = pend_q;
  assign wb_err_o = err_q;

  // Scoreboard and sticky error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end
endmodule

// File: rtl/rf_access_ctrl.sv
// Operand-fetch / writeback controller sitting between decode and execute.
// Reads the register file combinationally, bypasses same-cycle writeback
// data into the captured operands, and stalls issue on RAW/WAW hazards.
module rf_access_ctrl
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [IDX_W-1:0] iss_src1,
  input  logic [IDX_W-1:0] iss_src2,
  input  logic             iss_use1,
  input  logic             iss_use2,
  input  logic [IDX_W-1:0] iss_dst,
  input  logic             iss_wb,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [IDX_W-1:0] op_dst,
  output logic             op_wb,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_index,
  input  logic [DATA_W-1:0] wb_data,
  output logic [IDX_W-1:0] rf_rd_index1,
  output logic [IDX_W-1:0] rf_rd_index2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic             rf_wr_enable,
  output logic [IDX_W-1:0] rf_wr_index,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [NREG-1:0]  busy_mask,
  output logic             wb_err
);
  logic      op_valid_q, op_valid_d;
  data_t     op_a_q, op_a_d, op_b_q, op_b_d;
  reg_idx_t  op_dst_q, op_dst_d;
  logic      op_wb_q, op_wb_d;
  reg_mask_t clr_mask;
  logic [2:0] hazard;
  logic      stall, out_free, fire;

  assign rf_rd_index1 = iss_src1;
  assign rf_rd_index2 = iss_src2;
  assign rf_wr_enable = wb_valid;
  assign rf_wr_index  = wb_index;
  assign rf_wr_data   = wb_data;

  assign clr_mask = idx_mask(wb_index, wb_valid);
  assign stall    = |hazard;
  assign out_free = !op_valid_q || op_ready;
  assign iss_ready = out_free && !stall;
  assign fire     = iss_valid && iss_ready;

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (fire && iss_wb),
    .set_idx_i  (iss_dst),
    .clr_en_i   (wb_valid),
    .clr_idx_i  (wb_index),
    .src1_i     (iss_src1),
    .use1_i     (iss_use1),
    .src2_i     (iss_src2),
    .use2_i     (iss_use2),
    .dst_i      (iss_dst),
    .wb_i       (iss_wb),
    .pend_o     (busy_mask),
    .pend_eff_o (),
    .hazard_o   (hazard),
    .wb_err_o   (wb_err)
  );

  // Next operand-stage contents: load on fire (with writeback bypass),
  // drain on accept, otherwise hold.
  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_dst_d   = op_dst_q;
    op_wb_d    = op_wb_q;
    if (fire) begin
      op_valid_d = 1'b1;
      op_dst_d   = iss_dst;
      op_wb_d    = iss_wb;
      op_a_d     = !iss_use1 ? '0 : clr_mask[iss_src1] ? wb_data : rf_rd_data1;
      op_b_d     = !iss_use2 ? '0 : clr_mask[iss_src2] ? wb_data : rf_rd_data2;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end
  end

  // Operand-stage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_dst_q   <= '0;
      op_wb_q    <= 1'b0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_dst_q   <= op_dst_d;
      op_wb_q    <= op_wb_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_dst   = op_dst_q;
  assign op_wb    = op_wb_q;
endmodule

// File: tb/tb_rf_access_ctrl.sv
// Directed bench for rf_access_ctrl with a register-file model and a
// behavioural reference checked on every falling edge.
module tb_rf_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid, iss_use1, iss_use2, iss_wb;
  logic [1:0]  iss_src1, iss_src2, iss_dst;
  logic        iss_ready;
  logic        op_valid, op_ready, op_wb;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_dst;
  logic        wb_valid;
  logic [1:0]  wb_index;
  logic [15:0] wb_data;
  logic [1:0]  rf_rd_index1, rf_rd_index2, rf_wr_index;
  logic [15:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic        rf_wr_enable;
  logic [3:0]  busy_mask;
  logic        wb_err;

  logic [15:0] rf_mem [4] = '{16'h002a, 16'h0037, 16'h008b, 16'h00fd};

  // reference state
  logic [3:0]  m_pend = 4'b0;
  logic        m_valid = 1'b0, m_wb = 1'b0, m_err = 1'b0;
  logic [15:0] m_a = 16'h0, m_b = 16'h0;
  logic [1:0]  m_dst = 2'b0;
  logic        chk_en = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  assign rf_rd_data1 = rf_mem[rf_rd_index1];
  assign rf_rd_data2 = rf_mem[rf_rd_index2];

  rf_access_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_use1(iss_use1), .iss_use2(iss_use2),
    .iss_dst(iss_dst), .iss_wb(iss_wb),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_dst(op_dst), .op_wb(op_wb),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .rf_rd_index1(rf_rd_index1), .rf_rd_index2(rf_rd_index2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_wr_enable(rf_wr_enable), .rf_wr_index(rf_wr_index),
    .rf_wr_data(rf_wr_data),
    .busy_mask(busy_mask), .wb_err(wb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // A register is blocking if it has a write outstanding that is not
  // being retired by this cycle's writeback.
  function automatic logic busy_now(input logic [1:0] r);
    return m_pend[r] && !(wb_valid && wb_index == r);
  endfunction

  function automatic logic m_ready();
    logic blocked;
    blocked = (iss_use1 && busy_now(iss_src1)) || (iss_use2 && busy_now(iss_src2)) ||
              (iss_wb && busy_now(iss_dst));
    return (!m_valid || op_ready) && !blocked;
  endfunction

  function automatic logic [15:0] m_operand(input logic use_it, input logic [1:0] r);
    if (!use_it) return 16'h0;
    if (wb_valid && wb_index == r) return wb_data;
    return rf_mem[r];
  endfunction

  // Reference model plus register-file write port.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend  <= 4'b0;
      m_valid <= 1'b0;
      m_a     <= 16'h0;
      m_b     <= 16'h0;
      m_dst   <= 2'b0;
      m_wb    <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      if (iss_valid && m_ready()) begin
        m_valid <= 1'b1;
        m_a     <= m_operand(iss_use1, iss_src1);
        m_b     <= m_operand(iss_use2, iss_src2);
        m_dst   <= iss_dst;
        m_wb    <= iss_wb;
      end else if (op_ready) begin
        m_valid <= 1'b0;
      end
      for (int r = 0; r < 4; r++) begin
        if (iss_valid && m_ready() && iss_wb && iss_dst == 2'(r))
          m_pend[r] <= 1'b1;
        else if (wb_valid && wb_index == 2'(r))
          m_pend[r] <= 1'b0;
      end
      if (wb_valid && !m_pend[wb_index]) m_err <= 1'b1;
    end
    if (rst && wb_valid) rf_mem[wb_index] <= wb_data;
  end

  // Every-cycle comparison against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("iss_ready", {31'b0, iss_ready}, {31'b0, m_ready()});
      chk("op_valid",  {31'b0, op_valid},  {31'b0, m_valid});
      chk("op_a",      {16'b0, op_a},      {16'b0, m_a});
      chk("op_b",      {16'b0, op_b},      {16'b0, m_b});
      chk("op_dst",    {30'b0, op_dst},    {30'b0, m_dst});
      chk("op_wb",     {31'b0, op_wb},     {31'b0, m_wb});
      chk("busy_mask", {28'b0, busy_mask}, {28'b0, m_pend});
      chk("wb_err",    {31'b0, wb_err},    {31'b0, m_err});
      chk("rf_wr",     {13'b0, rf_wr_enable, rf_wr_index, rf_wr_data},
                       {13'b0, wb_valid, wb_index, wb_data});
      chk("rf_rd_idx", {28'b0, rf_rd_index1, rf_rd_index2},
                       {28'b0, iss_src1, iss_src2});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_use1 = 0; iss_use2 = 0; iss_wb = 0;
    iss_src1 = 0; iss_src2 = 0; iss_dst = 0;
    wb_valid = 0; wb_index = 0; wb_data = 16'h0;
  endtask

  task automatic issue(input logic [1:0] s1, input logic u1, input logic [1:0] s2,
                       input logic u2, input logic [1:0] d, input logic w);
    iss_valid = 1; iss_src1 = s1; iss_use1 = u1; iss_src2 = s2; iss_use2 = u2;
    iss_dst = d; iss_wb = w;
  endtask

  initial begin
    idle();
    op_ready = 1;
    #1 rst = 0;
    #1;
    chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
    chk("rst_busy",     {28'b0, busy_mask}, 32'd0);
    chk("rst_wb_err",   {31'b0, wb_err}, 32'd0);
    chk("rst_op_a",     {16'b0, op_a}, 32'd0);
    #2 rst = 1;
    chk_en = 1;
    cyc();

    // 1: plain read of r0/r1
    issue(2'd0, 1, 2'd1, 1, 2'd0, 0);
    #1 chk("t1_ready", {31'b0, iss_ready}, 32'd1);
    cyc();
    chk("t1_valid", {31'b0, op_valid}, 32'd1);
    chk("t1_op_a", {16'b0, op_a}, 32'h002a);
    chk("t1_op_b", {16'b0, op_b}, 32'h0037);

    // 2: pending write on r2, RAW stall, bypass release
    issue(2'd0, 0, 2'd0, 0, 2'd2, 1);
    cyc();
    chk("t2_busy", {28'b0, busy_mask}, 32'h4);
    issue(2'd2, 1, 2'd0, 0, 2'd0, 0);
    #1 chk("t2_stall", {31'b0, iss_ready}, 32'd0);
    cyc();
    wb_valid = 1; wb_index = 2'd2; wb_data = 16'h0123;
    #1 chk("t2_bypass_ready", {31'b0, iss_ready}, 32'd1);
    cyc();
    idle();
    chk("t2_op_a", {16'b0, op_a}, 32'h0123);
    chk("t2_busy_clr", {28'b0, busy_mask}, 32'h0);

    // 3: output hold under back-pressure
    issue(2'd3, 1, 2'd0, 1, 2'd0, 0);
    cyc();
    op_ready = 0;
    issue(2'd1, 1, 2'd0, 0, 2'd0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_ready", {31'b0, iss_ready}, 32'd0);
      chk("t3_valid", {31'b0, op_valid}, 32'd1);
      chk("t3_hold", {op_a, op_b}, {16'h00fd, 16'h002a});
      cyc();
    end
    op_ready = 1;
    #1 chk("t3_release", {31'b0, iss_ready}, 32'd1);
    cyc();
    chk("t3_next", {op_a, op_b}, {16'h0037, 16'h0000});

    // 4: writeback and new set on r3 in the same cycle -> set wins
    issue(2'd0, 0, 2'd0, 0, 2'd3, 1);
    cyc();
    chk("t4_busy", {28'b0, busy_mask}, 32'h8);
    wb_valid = 1; wb_index = 2'd3; wb_data = 16'h0777;
    #1;
    chk("t4_wr_en", {31'b0, rf_wr_enable}, 32'd1);
    chk("t4_ready", {31'b0, iss_ready}, 32'd1);
    cyc();
    idle();
    chk("t4_busy_set", {28'b0, busy_mask}, 32'h8);
    chk("t4_no_err", {31'b0, wb_err}, 32'd0);

    // 5: writeback to a non-pending register
    wb_valid = 1; wb_index = 2'd1; wb_data = 16'h0055;
    #1;
    chk("t5_wr", {15'b0, rf_wr_enable, rf_wr_data}, {15'b0, 1'b1, 16'h0055});
    cyc();
    idle();
    chk("t5_err", {31'b0, wb_err}, 32'd1);
    cyc();
    chk("t5_err_sticky", {31'b0, wb_err}, 32'd1);

    // 6: asynchronous reset mid-stall
    wb_valid = 1; wb_index = 2'd3; wb_data = 16'h0999;
    issue(2'd0, 0, 2'd0, 0, 2'd2, 1);
    cyc();
    idle();
    chk("t6_busy", {28'b0, busy_mask}, 32'h4);
    chk("t6_valid", {31'b0, op_valid}, 32'd1);
    op_ready = 0;
    issue(2'd2, 1, 2'd0, 0, 2'd0, 0);
    #1 chk("t6_stall", {31'b0, iss_ready}, 32'd0);
    #2 rst = 0;
    #1;
    chk("t6_rst_valid", {31'b0, op_valid}, 32'd0);
    chk("t6_rst_busy", {28'b0, busy_mask}, 32'd0);
    chk("t6_rst_err", {31'b0, wb_err}, 32'd0);
    #1 rst = 1;
    #1 chk("t6_ready", {31'b0, iss_ready}, 32'd1);
    cyc();
    idle();
    op_ready = 1;
    chk("t6_issue", {15'b0, op_valid, op_a}, {15'b0, 1'b1, 16'h0123});
    cyc();
    cyc();
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
Operand-fetch and writeback controller that drives the register_file from the other side of its interface. It issues the read indices, captures the operands, and performs writes.
- Tracks outstanding writes in a per-register scoreboard.
- Stalls on RAW/WAW hazards.
- Bypasses same-cycle writeback data, because register_file reads are combinational and writes commit at posedge clk.
- Sits between decode (issue side) and execute (operand/writeback side).

Parameters:
DATA_W, 16, register/operand width
IDX_W, 2, register index width
NREG, 4, number of registers (2**IDX_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
iss_valid  in  1  decode presents instruction
iss_ready  out  1  controller accepts instruction this cycle
iss_src1, iss_src2  in  IDX_W  source indices
iss_use1, iss_use2  in  1  source used
iss_dst  in  IDX_W  destination index
iss_wb  in  1  instruction will write iss_dst
op_valid  out  1  operands valid to execute
op_ready  in  1  execute accepts operands
op_a, op_b  out  DATA_W  operands
op_dst  out  IDX_W  destination, passed through
op_wb  out  1  write flag, passed through
wb_valid  in  1  execute writeback strobe
wb_index  in  IDX_W  writeback index
wb_data  in  DATA_W  writeback data
rf_rd_index1, rf_rd_index2  out  IDX_W  to register_file
rf_rd_data1, rf_rd_data2  in  DATA_W  from register_file
rf_wr_enable  out  1  to register_file
rf_wr_index  out  IDX_W  to register_file
rf_wr_data  out  DATA_W  to register_file
busy_mask  out  NREG  scoreboard pending bits
wb_err  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset (rst=0, asynchronous):
  - Registered outputs clear immediately: pend=0, op_valid=0, op_a=op_b=0, op_dst=0, op_wb=0, wb_err=0.
  - Combinational outputs keep following their inputs.
- Combinational paths:
  - rf_rd_index1=iss_src1, rf_rd_index2=iss_src2.
  - rf_wr_enable=wb_valid, rf_wr_index=wb_index, rf_wr_data=wb_data.
- Definitions:
  - clr[i] = wb_valid && wb_index==i.
  - pend_eff = pend & ~clr.
- Hazard (combinational):
  - stall if (iss_use1 && pend_eff[iss_src1]), or
  - (iss_use2 && pend_eff[iss_src2]), or
  - (iss_wb && pend_eff[iss_dst]).
- Output stage free: out_free = !op_valid || op_ready.
- iss_ready = out_free && !stall. It depends only on the iss_* fields and state, never on iss_valid.
- Issue fire = iss_valid && iss_ready. At the next edge:
  - op_valid=1.
  - op_dst=iss_dst, op_wb=iss_wb.
  - op_a = !iss_use1 ? 0 : clr[iss_src1] ? wb_data : rf_rd_data1. op_b is formed likewise.
- Operand latency:
  - Operands appear one cycle after fire.
  - Writeback data is usable by an issue in the same cycle via bypass.
- Output hold: with op_valid=1 and op_ready=0, op_* stay stable. If op_ready=1 and there is no fire, op_valid->0.
- Scoreboard, per register i at each edge:
  - pend[i] <= (fire && iss_wb && iss_dst==i) ? 1 : clr[i] ? 0 : pend[i].
  - When a set and a clear hit the same index, the set wins.
- If wb_valid hits a register with pend=0:
  - The write still goes to the register file.
  - wb_err is set and stays set until reset.
- busy_mask = pend (registered value).
- No internal writeback queue. Execute must not issue two writebacks in one cycle; wb_valid is a single strobe per cycle.

Decomposition:
- Package rf_pkg: DATA_W, IDX_W, NREG constants; reg_idx_t typedef (IDX_W bits); data_t typedef (DATA_W bits).
- Sub-module rf_scoreboard:
  - Holds the pend register with set/clear logic and set-priority.
  - Outputs pend_eff and a 3-query hazard result for src1, src2 and dst.
- The register_file instance lives in the parent datapath, not in this block.

Test Plan:
1. Registers preloaded 0x002a/0x0037/0x008b/0x00fd. Issue src1=0, src2=1, use both, op_ready=1 -> next cycle op_valid=1, op_a=0x002a, op_b=0x0037.
2. Issue dst=2, wb=1 -> busy_mask=4'b0100. Then issue src1=2 -> iss_ready=0. Then wb_valid, idx2, data 0x0123 in the same cycle -> iss_ready=1, op_a=0x0123 next cycle, busy_mask=0.
3. op_ready=0 for 3 cycles after a fire -> op_valid stays 1, op_a/op_b unchanged, iss_ready=0. op_ready=1 -> transfer, next issue accepted.
4. wb_valid idx3 and issue dst=3, wb=1 in the same cycle, with pend[3]=1 -> after the edge busy_mask[3]=1 and rf_wr_enable=1 that cycle.
5. wb_valid idx1, data 0x0055, with pend[1]=0 -> rf_wr_enable=1, rf_wr_data=0x0055, wb_err=1 and stays 1.
6. pend=4'b0100, op_valid=1, stall in progress; drive rst=0 between clock edges -> immediately op_valid=0, busy_mask=0, wb_err=0. After release, an issue of src1=2 is accepted at once.
